// File: rtl/mux2_arb_pkg.sv
// mux2_arb_pkg: shared types for the two-requester
// select arbiter (FSM states, select encoding).
package mux2_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT_A = 2'b01,
    GRANT_B = 2'b10
  } arb_state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux2_bus.sv
// mux2_bus: WIDTH-bit 2:1 AND-OR select.
// Ports: a, b data in; s select (1 = b); y out.
module mux2_bus #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH-1:0] y
);

  assign y = (~{WIDTH{s}} & a)
           | ( {WIDTH{s}} & b);

endmodule

// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter: round-robin A/B arbiter with bounded
// hold, driving a 2:1 select into a 1-entry output stage.
// Ports: clk, rst (async high); a_/b_ valid,data,ready
// requester side; y_ valid,data,ready consumer side;
// sel registered select (0 = A, 1 = B).
module mux2_rr_arbiter
  import mux2_arb_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             y_valid,
  output logic [WIDTH-1:0] y_data,
  input  logic             y_ready,
  output logic             sel
);

  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);

  arb_state_t    state;
  arb_state_t    state_nxt;
  logic          last;
  logic [CW-1:0] hold_cnt;
  logic [CW-1:0] hold_cnt_nxt;

  logic             out_free;
  logic             a_acc;
  logic             b_acc;
  logic             accept;
  logic             leave;
  logic [WIDTH-1:0] mux_y;

  assign out_free = !y_valid || y_ready;
  assign a_ready  = (state == GRANT_A) && out_free;
  assign b_ready  = (state == GRANT_B) && out_free;
  assign a_acc    = a_valid && a_ready;
  assign b_acc    = b_valid && b_ready;
  assign accept   = a_acc || b_acc;

  // Saturate so a lone requester can stream forever.
  assign hold_cnt_nxt =
    (accept && hold_cnt != HOLD_MAX)
      ? hold_cnt + CW'(1)
      : hold_cnt;

  mux2_bus #(
    .WIDTH (WIDTH)
  ) u_bus (
    .a (a_data),
    .b (b_data),
    .s (sel),
    .y (mux_y)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          a_valid && b_valid:
            state_nxt = (last == SEL_B)
                      ? GRANT_A : GRANT_B;
          a_valid && !b_valid:
            state_nxt = GRANT_A;
          !a_valid && b_valid:
            state_nxt = GRANT_B;
          default:
            state_nxt = IDLE;
        endcase
      end
      GRANT_A: begin
        if (b_valid &&
            (hold_cnt_nxt == HOLD_MAX || !a_valid))
          state_nxt = GRANT_B;
        else if (!a_valid)
          state_nxt = IDLE;
      end
      GRANT_B: begin
        if (a_valid &&
            (hold_cnt_nxt == HOLD_MAX || !b_valid))
          state_nxt = GRANT_A;
        else if (!b_valid)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign leave = (state != IDLE)
              && (state_nxt != state);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sel      <= SEL_A;
      last     <= SEL_B;
      hold_cnt <= '0;
      y_valid  <= 1'b0;
      y_data   <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt == GRANT_A)
        sel <= SEL_A;
      else if (state_nxt == GRANT_B)
        sel <= SEL_B;
      if (leave) begin
        last     <= (state == GRANT_B)
                  ? SEL_B : SEL_A;
        hold_cnt <= '0;
      end else begin
        hold_cnt <= hold_cnt_nxt;
      end
      if (accept) begin
        y_data  <= mux_y;
        y_valid <= 1'b1;
      end else if (y_ready) begin
        y_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// tb_mux2_rr_arbiter: vector table plus queue-based
// stream checks for the A/B round-robin arbiter.
module tb_mux2_rr_arbiter;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a_valid = 1'b0;
  logic b_valid = 1'b0;
  logic y_ready = 1'b0;
  logic [W-1:0] a_data = '0;
  logic [W-1:0] b_data = '0;
  logic use1 = 1'b0;

  logic a_ready0, b_ready0, y_valid0, sel0;
  logic a_ready1, b_ready1, y_valid1, sel1;
  logic [W-1:0] y_data0, y_data1;

  logic a_ready, b_ready, y_valid, sel;
  logic [W-1:0] y_data;

  assign a_ready = use1 ? a_ready1 : a_ready0;
  assign b_ready = use1 ? b_ready1 : b_ready0;
  assign y_valid = use1 ? y_valid1 : y_valid0;
  assign y_data  = use1 ? y_data1  : y_data0;
  assign sel     = use1 ? sel1     : sel0;

  mux2_rr_arbiter #(.WIDTH(W), .MAX_HOLD(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .a_valid (a_valid),
    .a_data  (a_data),
    .a_ready (a_ready0),
    .b_valid (b_valid),
    .b_data  (b_data),
    .b_ready (b_ready0),
    .y_valid (y_valid0),
    .y_data  (y_data0),
    .y_ready (y_ready),
    .sel     (sel0)
  );

  mux2_rr_arbiter #(.WIDTH(W), .MAX_HOLD(1)) dut1 (
    .clk     (clk),
    .rst     (rst),
    .a_valid (a_valid),
    .a_data  (a_data),
    .a_ready (a_ready1),
    .b_valid (b_valid),
    .b_data  (b_data),
    .b_ready (b_ready1),
    .y_valid (y_valid1),
    .y_data  (y_data1),
    .y_ready (y_ready),
    .sel     (sel1)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;

  logic [W-1:0] a_q[$];
  logic [W-1:0] b_q[$];
  logic [W-1:0] exp_q[$];
  bit a_en, b_en;
  int exp_sel;
  int cyc_cnt, out_cnt, out_first, out_last;

  typedef struct {
    logic av; logic [W-1:0] ad;
    logic bv; logic [W-1:0] bd;
    logic yr;
    logic ar; logic br; logic yv;
    logic [W-1:0] yd; logic sl;
  } vec_t;

  vec_t tv[10];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic drive();
    a_valid = a_en && (a_q.size() > 0);
    a_data  = a_valid ? a_q[0] : '0;
    b_valid = b_en && (b_q.size() > 0);
    b_data  = b_valid ? b_q[0] : '0;
  endtask

  task automatic cyc();
    bit af, bf;
    @(negedge clk);
    cyc_cnt++;
    chk("one_ready", {31'd0, a_ready & b_ready}, 0);
    if (exp_sel >= 0)
      chk("sel_fixed", {31'd0, sel}, exp_sel);
    if (y_valid && y_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_word: got %0h expected none",
                 y_data);
      end else begin
        chk("y_data", {24'd0, y_data},
            {24'd0, exp_q.pop_front()});
      end
      if (out_cnt == 0) out_first = cyc_cnt;
      out_last = cyc_cnt;
      out_cnt++;
    end
    af = a_valid && a_ready;
    bf = b_valid && b_ready;
    @(posedge clk);
    #1;
    if (af) void'(a_q.pop_front());
    if (bf) void'(b_q.pop_front());
    drive();
  endtask

  task automatic run(input int maxc,
                     input string name);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < maxc) begin
      cyc();
      n++;
    end
    chk({name, "_done"}, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    a_en = 1'b0;
    b_en = 1'b0;
    y_ready = 1'b1;
    a_q.delete();
    b_q.delete();
    exp_q.delete();
    exp_sel = -1;
    drive();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc_cnt = 0;
    out_cnt = 0;
    out_first = 0;
    out_last = 0;
  endtask

  initial begin
    logic [W-1:0] hold;

    tv[0] = '{1'b1, 8'h31, 1'b1, 8'h5A, 1'b1,
              1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
    tv[1] = '{1'b1, 8'h31, 1'b1, 8'h5A, 1'b1,
              1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
    tv[2] = '{1'b1, 8'h32, 1'b1, 8'h5A, 1'b1,
              1'b1, 1'b0, 1'b1, 8'h31, 1'b0};
    tv[3] = '{1'b0, 8'h00, 1'b1, 8'h5A, 1'b1,
              1'b1, 1'b0, 1'b1, 8'h32, 1'b0};
    tv[4] = '{1'b0, 8'h00, 1'b1, 8'h5A, 1'b1,
              1'b0, 1'b1, 1'b0, 8'h32, 1'b1};
    tv[5] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1,
              1'b0, 1'b1, 1'b1, 8'h5A, 1'b1};
    tv[6] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1,
              1'b0, 1'b0, 1'b0, 8'h5A, 1'b1};
    tv[7] = '{1'b0, 8'h00, 1'b1, 8'h77, 1'b1,
              1'b0, 1'b0, 1'b0, 8'h5A, 1'b1};
    tv[8] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1,
              1'b0, 1'b1, 1'b0, 8'h5A, 1'b1};
    tv[9] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1,
              1'b0, 1'b0, 1'b0, 8'h5A, 1'b1};

    // reset mid-stream, then A wins first tie
    do_reset();
    b_q.push_back(8'h99);
    b_q.push_back(8'h98);
    exp_q.push_back(8'h99);
    b_en = 1'b1;
    drive();
    cyc();
    cyc();
    y_ready = 1'b0;
    #1;
    chk("t1_pre_valid", {31'd0, y_valid}, 1);
    chk("t1_pre_sel", {31'd0, sel}, 1);
    rst = 1'b1;
    #1;
    chk("t1_rst_valid", {31'd0, y_valid}, 0);
    chk("t1_rst_data", {24'd0, y_data}, 0);
    chk("t1_rst_sel", {31'd0, sel}, 0);
    do_reset();
    a_q.push_back(8'h11);
    b_q.push_back(8'h22);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    a_en = 1'b1;
    b_en = 1'b1;
    drive();
    run(20, "t1");

    // lone requester ignores hold limit
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      a_q.push_back(W'(i));
      exp_q.push_back(W'(i));
    end
    a_en = 1'b1;
    exp_sel = 0;
    drive();
    run(20, "t2");
    chk("t2_first", out_first, 3);
    chk("t2_gapless", out_last - out_first, 5);

    // both always valid, hold of 4
    do_reset();
    for (int i = 0; i < 12; i++) begin
      a_q.push_back(W'(8'hA0 + i));
      b_q.push_back(W'(8'hB0 + i));
    end
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++)
        exp_q.push_back(W'(8'hA0 + 4 * k + i));
      for (int i = 0; i < 4; i++)
        exp_q.push_back(W'(8'hB0 + 4 * k + i));
    end
    a_en = 1'b1;
    b_en = 1'b1;
    drive();
    run(60, "t3");
    chk("t3_first", out_first, 3);
    chk("t3_gapless", out_last - out_first, 23);

    // stall during GRANT_A
    do_reset();
    for (int i = 0; i < 8; i++) begin
      a_q.push_back(W'(8'h40 + i));
      b_q.push_back(W'(8'h50 + i));
    end
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++)
        exp_q.push_back(W'(8'h40 + 4 * k + i));
      for (int i = 0; i < 4; i++)
        exp_q.push_back(W'(8'h50 + 4 * k + i));
    end
    a_en = 1'b1;
    b_en = 1'b1;
    drive();
    repeat (4) cyc();
    y_ready = 1'b0;
    hold = exp_q[0];
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t4_a_ready", {31'd0, a_ready}, 0);
      chk("t4_y_valid", {31'd0, y_valid}, 1);
      chk("t4_y_held", {24'd0, y_data},
          {24'd0, hold});
      chk("t4_sel", {31'd0, sel}, 0);
    end
    y_ready = 1'b1;
    run(60, "t4");

    // A drops with B waiting; drop without accept
    do_reset();
    for (int i = 0; i < 10; i++) begin
      a_valid = tv[i].av;
      a_data  = tv[i].ad;
      b_valid = tv[i].bv;
      b_data  = tv[i].bd;
      y_ready = tv[i].yr;
      @(negedge clk);
      chk($sformatf("t5_a_ready[%0d]", i),
          {31'd0, a_ready}, {31'd0, tv[i].ar});
      chk($sformatf("t5_b_ready[%0d]", i),
          {31'd0, b_ready}, {31'd0, tv[i].br});
      chk($sformatf("t5_y_valid[%0d]", i),
          {31'd0, y_valid}, {31'd0, tv[i].yv});
      chk($sformatf("t5_y_data[%0d]", i),
          {24'd0, y_data}, {24'd0, tv[i].yd});
      chk($sformatf("t5_sel[%0d]", i),
          {31'd0, sel}, {31'd0, tv[i].sl});
      @(posedge clk);
      #1;
    end

    // hold of 1: strict alternation
    use1 = 1'b1;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      a_q.push_back(W'(8'hA0 + i));
      b_q.push_back(W'(8'hB0 + i));
      exp_q.push_back(W'(8'hA0 + i));
      exp_q.push_back(W'(8'hB0 + i));
    end
    a_en = 1'b1;
    b_en = 1'b1;
    drive();
    run(40, "t6");
    chk("t6_first", out_first, 3);
    chk("t6_gapless", out_last - out_first, 11);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
